// File: rtl/cp0_regfile_if.sv
// Shared CP0 types and the MFC0/MTC0 access bus between the pipeline and the CP0 register file.
package cp0_pkg;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] extra;
    logic [31:0] pc;
    logic        delayslot;
  } except_req_t;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] ebase;
  } cp0_regs_t;
endpackage

interface cp0_regfile_if;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;

  modport master (output raddr, rsel, we, waddr, wsel, wdata, input rdata);
  modport slave  (input raddr, rsel, we, waddr, wsel, wdata, output rdata);
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, Count/Compare timer, interrupt sampling,
// and exception/ERET commit from the exception-decision stage.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0001_8000
) (
  input  logic                clk,
  input  logic                rst,
  cp0_regfile_if.slave        cp0_bus,
  input  logic [5:0]          i_ext_int,
  input  except_req_t         i_except_req,
  output cp0_regs_t           o_cp0_regs,
  output logic [7:0]          o_interrupt_req
);
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  logic [31:0] r_status, r_epc, r_badvaddr, r_count, r_compare;
  logic [17:0] r_ebase;
  logic [7:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic        r_bd, r_ti, r_iv, r_tick;

  logic [31:0] w_status_next, w_epc_next, w_badvaddr_next, w_count_next, w_compare_next;
  logic [17:0] w_ebase_next;
  logic [7:0]  w_ip_next;
  logic [4:0]  w_exc_code_next;
  logic        w_bd_next, w_ti_next, w_iv_next, w_tick_next;

  logic        w_wr_ok, w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc, w_wr_ebase;
  logic        w_exc, w_eret, w_addr_exc, w_match;
  logic [31:0] w_cause, w_ebase;

  // The instruction behind a committed exception never gets to perform its MTC0.
  assign w_wr_ok      = cp0_bus.we && !i_except_req.valid;
  assign w_wr_count   = w_wr_ok && cp0_bus.waddr == 5'd9  && cp0_bus.wsel == 3'd0;
  assign w_wr_compare = w_wr_ok && cp0_bus.waddr == 5'd11 && cp0_bus.wsel == 3'd0;
  assign w_wr_status  = w_wr_ok && cp0_bus.waddr == 5'd12 && cp0_bus.wsel == 3'd0;
  assign w_wr_cause   = w_wr_ok && cp0_bus.waddr == 5'd13 && cp0_bus.wsel == 3'd0;
  assign w_wr_epc     = w_wr_ok && cp0_bus.waddr == 5'd14 && cp0_bus.wsel == 3'd0;
  assign w_wr_ebase   = w_wr_ok && cp0_bus.waddr == 5'd15 && cp0_bus.wsel == 3'd1;

  assign w_exc      = i_except_req.valid && !i_except_req.eret;
  assign w_eret     = i_except_req.valid && i_except_req.eret;
  assign w_addr_exc = i_except_req.code inside {EXC_ADEL, EXC_ADES, EXC_TLBL, EXC_TLBS, EXC_MOD};
  assign w_match    = r_count == r_compare;

  assign w_cause = {r_bd, r_ti, 6'd0, r_iv, 7'd0, r_ip, 1'b0, r_exc_code, 2'b00};
  assign w_ebase = {2'b10, r_ebase, 12'd0};

  always_comb begin
    w_tick_next     = ~r_tick;
    w_count_next    = w_wr_count ? cp0_bus.wdata : r_count + {31'd0, r_tick};
    w_compare_next  = w_wr_compare ? cp0_bus.wdata : r_compare;
    // A Compare write clears ti even when the match fires in the same cycle.
    w_ti_next       = !w_wr_compare && (r_ti || w_match);
    w_ip_next       = {i_ext_int[5] | w_ti_next, i_ext_int[4:0],
                       w_wr_cause ? cp0_bus.wdata[9:8] : r_ip[1:0]};
    w_iv_next       = w_wr_cause ? cp0_bus.wdata[23] : r_iv;
    w_status_next   = w_wr_status ? (cp0_bus.wdata & STATUS_WMASK) : r_status;
    w_ebase_next    = w_wr_ebase ? cp0_bus.wdata[29:12] : r_ebase;
    w_epc_next      = w_wr_epc ? cp0_bus.wdata : r_epc;
    w_bd_next       = r_bd;
    w_exc_code_next = r_exc_code;
    w_badvaddr_next = r_badvaddr;

    if (w_exc) begin
      // Nested exceptions keep the original return point.
      if (!r_status[1]) begin
        w_epc_next = i_except_req.delayslot ? i_except_req.pc - 32'd4 : i_except_req.pc;
        w_bd_next  = i_except_req.delayslot;
      end
      w_status_next[1] = 1'b1;
      w_exc_code_next  = i_except_req.code;
      if (w_addr_exc) w_badvaddr_next = i_except_req.extra;
    end else if (w_eret) begin
      if (r_status[2]) w_status_next[2] = 1'b0;
      else             w_status_next[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= STATUS_RESET;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_ebase    <= '0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_bd       <= 1'b0;
      r_ti       <= 1'b0;
      r_iv       <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_status   <= w_status_next;
      r_epc      <= w_epc_next;
      r_badvaddr <= w_badvaddr_next;
      r_count    <= w_count_next;
      r_compare  <= w_compare_next;
      r_ebase    <= w_ebase_next;
      r_ip       <= w_ip_next;
      r_exc_code <= w_exc_code_next;
      r_bd       <= w_bd_next;
      r_ti       <= w_ti_next;
      r_iv       <= w_iv_next;
      r_tick     <= w_tick_next;
    end
  end

  always_comb begin
    cp0_bus.rdata = '0;
    case ({cp0_bus.raddr, cp0_bus.rsel})
      {5'd8,  3'd0}: cp0_bus.rdata = r_badvaddr;
      {5'd9,  3'd0}: cp0_bus.rdata = r_count;
      {5'd11, 3'd0}: cp0_bus.rdata = r_compare;
      {5'd12, 3'd0}: cp0_bus.rdata = r_status;
      {5'd13, 3'd0}: cp0_bus.rdata = w_cause;
      {5'd14, 3'd0}: cp0_bus.rdata = r_epc;
      {5'd15, 3'd0}: cp0_bus.rdata = PRID;
      {5'd15, 3'd1}: cp0_bus.rdata = w_ebase;
      default:       cp0_bus.rdata = '0;
    endcase
  end

  assign o_cp0_regs = '{status: r_status, cause: w_cause, epc: r_epc, badvaddr: r_badvaddr,
                        count: r_count, compare: r_compare, ebase: w_ebase};
  assign o_interrupt_req = r_ip & r_status[15:8];
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the CPU core. It holds Status, Cause, EPC, BadVAddr, Count, Compare, PRId and EBase, and services MFC0 reads and MTC0 writes. It commits the `except_req_t` produced by the exception-decision stage (EXL/EPC/Cause/BadVAddr update, ERET return). It also generates the masked `interrupt_req` vector and the `cp0_regs_t` snapshot that the exception stage consumes.

## Interface
- `PRID`, default 32'h0001_8000, constant value returned by PRId (reg 15, sel 0).
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `raddr`  in  5  MFC0 register number.
- `rsel`  in  3  MFC0 select.
- `rdata`  out  32  MFC0 read data; combinational from current register state.
- `we`  in  1  MTC0 write enable.
- `waddr`  in  5  MTC0 register number.
- `wsel`  in  3  MTC0 select.
- `wdata`  in  32  MTC0 write data.
- `ext_int`  in  6  external hardware interrupt lines, level-sensitive.
- `except_req`  in  `except_req_t`  committed exception/ERET request (valid, eret, code, extra, pc, delayslot).
- `cp0_regs`  out  `cp0_regs_t`  registered CP0 state.
- `interrupt_req`  out  8  `cause.ip & status.im`.

## Operation
- Register map: BadVAddr 8/0 (read-only), Count 9/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0, PRId 15/0 (read-only), EBase 15/1.
- Unmapped addr/sel: reads return 0; writes are ignored.
- Writable masks:
  - Status: bev[22], im[15:8], erl[2], exl[1], ie[0]. All other bits read 0.
  - Cause: iv[23], ip[9:8]. bd[31], ti[30], ip[15:10] and exc_code[6:2] are hardware-only.
  - EBase: bits [29:12]. Bits [31:30] fixed to 2'b10, bits [11:0] read 0.
  - Count, Compare, EPC: full 32 bits.
- Reset values:
  - Status: bev=1, all other bits 0.
  - Cause: 0. EPC, BadVAddr, Count, Compare: 0.
  - EBase: 32'h8000_0000.
  - Tick toggle: 0.
  - `interrupt_req` = 0.
- Count: 1-bit tick toggles every cycle. Count increments when tick=1, i.e. once per 2 cycles. Wraps 32'hFFFF_FFFF→0.
- An MTC0 to Count loads wdata and suppresses that cycle's increment. The tick phase is not reset by the write.
- Timer:
  - Match when `count == compare` on current register values: set cause.ti next cycle. ti is sticky.
  - An MTC0 to Compare clears ti. If a match and a Compare write occur in the same cycle, the clear wins.
- Interrupt sampling, every cycle: `cause.ip[7] <= ext_int[5] | ti` (using the updated ti), and `cause.ip[6:2] <= ext_int[4:0]`. ip[1:0] are software-only.
- Exception commit, when `except_req.valid && !except_req.eret`:
  - If status.exl==0:
    - epc <= delayslot ? pc-32'd4 : pc.
    - cause.bd <= delayslot.
  - If status.exl==1: EPC and BD are left unchanged.
  - status.exl <= 1.
  - cause.exc_code <= code.
  - If code ∈ {ADEL, ADES, TLBL, TLBS, MOD}: badvaddr <= extra.
- ERET commit, when `except_req.valid && except_req.eret`:
  - If status.erl: erl <= 0.
  - Otherwise: exl <= 0.
- Priority: a valid except_req discards a simultaneous MTC0, because the writer is the faulting or squashed instruction.
  - A Count increment still occurs during an exception.
  - Interrupt sampling and the timer still occur during an exception.

## Timing
- All state updates are visible on `cp0_regs`/`rdata` one cycle after the triggering edge. There is no write→read bypass: an MFC0 in the same cycle as an MTC0 returns the old value.
- `ext_int` rising at cycle t → cause.ip at t+1 → `interrupt_req` at t+1 (combinational from registers).
- Count==Compare seen at cycle t → ti=1 and ip[7]=1 at t+1.
- Exception commit at edge t → exl=1 at t+1. The exception stage sees exl=1 and masks further interrupts from t+1.
- Reset mid-operation: all registers return to reset values on the next edge. except_req and MTC0 in that cycle are ignored.

## Test plan
- Reset, then read every mapped register → Status=32'h0040_0000, EBase=32'h8000_0000, PRId=PRID, all others 0. Unmapped 7/0 reads 0.
- MTC0 Status=32'hFFFF_FFFF → reads back 32'h0040_FF07. MTC0 Cause=32'hFFFF_FFFF → only iv and ip[1:0] set (32'h0080_0300). With im[1]=1: interrupt_req=8'h02 on the next cycle.
- Compare=10, Count=0, im[7]=1:
  - ti=1 and interrupt_req[7]=1 exactly one cycle after Count reads 10 (about 20 cycles later).
  - MTC0 Compare clears ti.
  - Count=32'hFFFF_FFFF wraps to 0.
- except_req {valid, code=ADEL, extra=32'h1234_5679, pc=32'hBFC0_0100, delayslot=1} with exl=0:
  - epc=32'hBFC0_00FC, bd=1, exc_code=ADEL, badvaddr=32'h1234_5679, exl=1.
  - A second exception with exl=1 leaves EPC unchanged.
- ERET with erl=1, exl=1 → erl=0, exl stays 1. A second ERET → exl=0.
- Same-cycle except_req and MTC0 EPC=32'hDEAD_BEEF → EPC holds the exception value. Same-cycle Compare write and match → ti stays 0.
